// File: rtl/ofs_fim_eth_tx_axis_arb_if.sv
// ofs_fim_eth_tx_axis_arb_if
// Bundles the NUM_CH client TX AXI-S channels (s_*) and the merged MAC TX
// stream (m_*) of the TX arbiter.
//   master : arbiter side. Consumes s_*, drives s_tready, drives m_*, sees m_tready.
//   slave  : environment side (clients + MAC). The mirror image of master.
// Channel c occupies slice c of every s_* vector.
interface ofs_fim_eth_tx_axis_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 512,
  parameter int USER_W = 8
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEST_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tready;
  logic [NUM_CH-1:0]        s_tlast;
  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH*KEEP_W-1:0] s_tkeep;
  logic [NUM_CH*USER_W-1:0] s_tuser;

  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [DATA_W-1:0]        m_tdata;
  logic [KEEP_W-1:0]        m_tkeep;
  logic [USER_W-1:0]        m_tuser;
  logic [DEST_W-1:0]        m_tdest;

  modport master (
    input  s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tdest
  );

  modport slave (
    output s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tdest
  );
endinterface

// File: rtl/ofs_fim_eth_tx_axis_arb.sv
// ofs_fim_eth_tx_axis_arb
// Packet-granular round-robin merge of NUM_CH client TX AXI-S streams into a
// single MAC TX stream. A channel owns the output from its first beat until
// the beat carrying tlast is accepted; beats of different channels never
// interleave. One idle arbitration cycle separates consecutive packets.
//
// Ports
//   clk     : single clock
//   rst     : asynchronous, active-high reset
//   axis    : ofs_fim_eth_tx_axis_arb_if.master -- s_* client channels, m_* MAC stream,
//             m_tdest = source channel of the current m beat
//   pkt_cnt : NUM_CH x 32-bit forwarded-packet counters (slice c = channel c)
//
// Optional feature
//   OFS_FIM_ETH_ARB_PKT_CNT_EN : when defined, pkt_cnt counts packets consumed
//   from m_* per source channel (wrapping 32-bit). When undefined, pkt_cnt is
//   tied to zero and no counter logic exists.
module ofs_fim_eth_tx_axis_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 512,
  parameter int USER_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  ofs_fim_eth_tx_axis_arb_if.master    axis,
  output logic [NUM_CH*32-1:0]         pkt_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int DEST_W = $clog2(NUM_CH);
  localparam logic [DEST_W:0] NCH = (DEST_W+1)'(NUM_CH);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [DEST_W-1:0] grant;
  logic [DEST_W-1:0] rr_ptr;

  // output register
  logic              m_tvalid_q;
  logic              m_tlast_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic [KEEP_W-1:0] m_tkeep_q;
  logic [USER_W-1:0] m_tuser_q;
  logic [DEST_W-1:0] m_tdest_q;

  // the output register can take a beat when it is empty or being drained
  logic fwd_ok;
  assign fwd_ok = !m_tvalid_q || axis.m_tready;

  // ------------------------------------------------------------------
  // Round-robin pick: first requester scanning upward from rr_ptr
  // ------------------------------------------------------------------
  logic              any_req;
  logic [DEST_W-1:0] pick;
  logic [DEST_W-1:0] rr_nxt;

  assign any_req = |axis.s_tvalid;

  always_comb begin
    logic             found;
    logic [DEST_W:0]  sum;
    logic [DEST_W-1:0] idx;
    found = 1'b0;
    pick  = rr_ptr;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr} + (DEST_W+1)'(i);
      if (sum >= NCH) sum = sum - NCH;
      idx = sum[DEST_W-1:0];
      if (!found && axis.s_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    logic [DEST_W:0] nxt;
    nxt = {1'b0, pick} + (DEST_W+1)'(1);
    if (nxt == NCH) nxt = '0;
    rr_nxt = nxt[DEST_W-1:0];
  end

  // ------------------------------------------------------------------
  // Granted-channel mux
  // ------------------------------------------------------------------
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic [USER_W-1:0] sel_user;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == DEST_W'(c)) begin
        sel_valid = axis.s_tvalid[c];
        sel_last  = axis.s_tlast[c];
        sel_data  = axis.s_tdata[c*DATA_W +: DATA_W];
        sel_keep  = axis.s_tkeep[c*KEEP_W +: KEEP_W];
        sel_user  = axis.s_tuser[c*USER_W +: USER_W];
      end
    end
  end

  // Ready goes only to the owner of the output, and only while LOCKED; the
  // IDLE cycle after each packet is the arbitration slot.
  logic [NUM_CH-1:0] s_tready_c;
  always_comb begin
    s_tready_c = '0;
    if (state == LOCKED) s_tready_c[grant] = fwd_ok;
  end

  logic accept;
  assign accept = (state == LOCKED) && sel_valid && fwd_ok;

  // ------------------------------------------------------------------
  // FSM + output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tdest_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= pick;
            rr_ptr <= rr_nxt;
            state  <= LOCKED;
          end
        end
        LOCKED: begin
          // a stalled owner keeps the lock indefinitely; no timeout
          if (accept && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= sel_last;
        m_tdata_q  <= sel_data;
        m_tkeep_q  <= sel_keep;
        m_tuser_q  <= sel_user;
        m_tdest_q  <= grant;
      end else if (axis.m_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign axis.s_tready = s_tready_c;
  assign axis.m_tvalid = m_tvalid_q;
  assign axis.m_tlast  = m_tlast_q;
  assign axis.m_tdata  = m_tdata_q;
  assign axis.m_tkeep  = m_tkeep_q;
  assign axis.m_tuser  = m_tuser_q;
  assign axis.m_tdest  = m_tdest_q;

  // ------------------------------------------------------------------
  // Per-channel packet counters
  // ------------------------------------------------------------------
`ifdef OFS_FIM_ETH_ARB_PKT_CNT_EN
  logic m_eop_fire;
  assign m_eop_fire = m_tvalid_q && axis.m_tready && m_tlast_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         cnt <= '0;
      else if (m_eop_fire && m_tdest_q == DEST_W'(c))  cnt <= cnt + 32'd1;
    end
    assign pkt_cnt[c*32 +: 32] = cnt;
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_ofs_fim_eth_tx_axis_arb.sv
// Directed bench for ofs_fim_eth_tx_axis_arb (NUM_CH=4, DATA_W=64, USER_W=8).
// Client channels are modelled by a tiny packet source per channel; beat data
// is 0xD000_0000 | ch<<16 | pkt_id<<8 | beat so every beat is unique.
module tb_ofs_fim_eth_tx_axis_arb;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int USER_W = 8;

  logic clk;
  logic rst;
  logic [NUM_CH*32-1:0] pkt_cnt;

  ofs_fim_eth_tx_axis_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  ofs_fim_eth_tx_axis_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .axis    (bus),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  int len  [NUM_CH];
  int beat [NUM_CH];
  int pkts [NUM_CH];
  int pid  [NUM_CH];
  logic [NUM_CH-1:0] gate;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bd(input int c, input int p, input int b);
    return 64'hD000_0000 | (64'(c) << 16) | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic drive_src();
    for (int c = 0; c < NUM_CH; c++) begin
      logic v;
      v = (pkts[c] > 0) && !gate[c];
      bus.s_tvalid[c]            = v;
      bus.s_tlast[c]             = v && (beat[c] == len[c] - 1);
      bus.s_tdata[c*64 +: 64]    = v ? bd(c, pid[c], beat[c]) : 64'h0;
      bus.s_tkeep[c*8 +: 8]      = v ? 8'hFF : 8'h00;
      bus.s_tuser[c*8 +: 8]      = v ? 8'(8'h10 + c) : 8'h00;
    end
  endtask

  // one clock: note accepted beats, advance the sources, settle, sample
  task automatic tick();
    logic [NUM_CH-1:0] acc;
    acc = bus.s_tvalid & bus.s_tready;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc[c]) begin
        if (beat[c] == len[c] - 1) begin
          beat[c] = 0;
          pkts[c] = pkts[c] - 1;
          pid[c]  = pid[c] + 1;
        end else begin
          beat[c] = beat[c] + 1;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic expm(input string tag, input logic v, input logic [63:0] d,
                      input logic l, input int dest);
    chk({tag, "_vld"}, 64'(bus.m_tvalid), 64'(v));
    if (v) begin
      chk({tag, "_data"}, bus.m_tdata, d);
      chk({tag, "_last"}, 64'(bus.m_tlast), 64'(l));
      chk({tag, "_dest"}, 64'(bus.m_tdest), 64'(dest));
      chk({tag, "_keep"}, 64'(bus.m_tkeep), 64'hFF);
      chk({tag, "_user"}, 64'(bus.m_tuser), 64'(8'h10 + dest));
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      pkts[c] = 0;
      beat[c] = 0;
    end
    drive_src();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int exp_ch  [5];
    int exp_pid [5];
    exp_ch  = '{0, 1, 2, 3, 0};
    exp_pid = '{1, 0, 1, 0, 2};

    rst          = 1'b1;
    gate         = '0;
    bus.m_tready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      len[c] = 1; beat[c] = 0; pkts[c] = 0; pid[c] = 0;
    end
    drive_src();
    #1;
    // ---- reset state
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'h0);
    chk("rst_m_tlast",  64'(bus.m_tlast),  64'h0);
    chk("rst_m_tdata",  bus.m_tdata,       64'h0);
    chk("rst_m_tdest",  64'(bus.m_tdest),  64'h0);
    chk("rst_s_tready", 64'(bus.s_tready), 64'h0);
    chk("rst_pkt_cnt",  64'(pkt_cnt[63:0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ---- A: ch0 and ch2 each 3 beats; ch0 first, one idle cycle, then ch2
    len[0] = 3; pkts[0] = 1;
    len[2] = 3; pkts[2] = 1;
    drive_src();
    #1;
    chk("A_idle_rdy", 64'(bus.s_tready), 64'h0);
    tick(); expm("A1", 1'b0, 64'h0, 1'b0, 0);
    chk("A1_rdy", 64'(bus.s_tready), 64'h1);
    tick(); expm("A2", 1'b1, bd(0, 0, 0), 1'b0, 0);
    tick(); expm("A3", 1'b1, bd(0, 0, 1), 1'b0, 0);
    tick(); expm("A4", 1'b1, bd(0, 0, 2), 1'b1, 0);
    chk("A4_rdy", 64'(bus.s_tready), 64'h0);
    tick(); expm("A5", 1'b0, 64'h0, 1'b0, 0);
    tick(); expm("A6", 1'b1, bd(2, 0, 0), 1'b0, 2);
    tick(); expm("A7", 1'b1, bd(2, 0, 1), 1'b0, 2);
    tick(); expm("A8", 1'b1, bd(2, 0, 2), 1'b1, 2);
    tick(); expm("A9", 1'b0, 64'h0, 1'b0, 0);

    // ---- B: after reset all four channels request 1-beat packets
    reset_pulse();
    for (int c = 0; c < NUM_CH; c++) begin
      len[c] = 1; pkts[c] = 1;
    end
    pkts[0] = 2;
    drive_src();
    #1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 2 == 0 && k <= 10)
        expm($sformatf("B%0d", k), 1'b1, bd(exp_ch[k/2-1], exp_pid[k/2-1], 0), 1'b1, exp_ch[k/2-1]);
      else
        expm($sformatf("B%0d", k), 1'b0, 64'h0, 1'b0, 0);
    end
    chk("B_end_rdy", 64'(bus.s_tready), 64'h0);

    // ---- C: ch1 beat 0xA5 stalled by m_tready=0 for 5 cycles
    bus.m_tready          = 1'b0;
    bus.s_tvalid          = 4'b0010;
    bus.s_tlast           = 4'b0000;
    bus.s_tdata[64 +: 64] = 64'hA5;
    bus.s_tkeep[8 +: 8]   = 8'hFF;
    bus.s_tuser[8 +: 8]   = 8'h11;
    clk1();
    chk("C_grant_rdy", 64'(bus.s_tready), 64'h2);
    chk("C_grant_vld", 64'(bus.m_tvalid), 64'h0);
    clk1();
    expm("C_b0", 1'b1, 64'hA5, 1'b0, 1);
    chk("C_b0_rdy", 64'(bus.s_tready), 64'h0);
    bus.s_tdata[64 +: 64] = 64'hB6;
    bus.s_tlast           = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      clk1();
      chk($sformatf("C_hold%0d_data", k), bus.m_tdata, 64'hA5);
      chk($sformatf("C_hold%0d_vld", k), 64'(bus.m_tvalid), 64'h1);
      chk($sformatf("C_hold%0d_rdy", k), 64'(bus.s_tready), 64'h0);
    end
    bus.m_tready = 1'b1;
    #1;
    chk("C_release_rdy", 64'(bus.s_tready), 64'h2);
    clk1();
    expm("C_b1", 1'b1, 64'hB6, 1'b1, 1);
    bus.s_tvalid = 4'b0000;
    bus.s_tlast  = 4'b0000;
    clk1();
    chk("C_drain_vld", 64'(bus.m_tvalid), 64'h0);
    chk("C_drain_rdy", 64'(bus.s_tready), 64'h0);
    drive_src();
    #1;

    // ---- G: owner ch0 drops tvalid mid-packet; ch1 must wait
    len[0] = 2; pkts[0] = 1;
    len[1] = 1; pkts[1] = 1;
    drive_src();
    #1;
    tick(); chk("G1_rdy", 64'(bus.s_tready), 64'h1);
    tick(); expm("G2", 1'b1, bd(0, 3, 0), 1'b0, 0);
    gate[0] = 1'b1;
    drive_src();
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("G_gap%0d_vld", k), 64'(bus.m_tvalid), 64'h0);
      chk($sformatf("G_gap%0d_rdy", k), 64'(bus.s_tready), 64'h1);
    end
    gate[0] = 1'b0;
    drive_src();
    #1;
    tick(); expm("G3", 1'b1, bd(0, 3, 1), 1'b1, 0);
    tick(); expm("G4", 1'b0, 64'h0, 1'b0, 0);
    tick(); expm("G5", 1'b1, bd(1, 1, 0), 1'b1, 1);
    tick(); expm("G6", 1'b0, 64'h0, 1'b0, 0);

    // ---- D: reset after beat 2 of a 4-beat ch3 packet
    len[3] = 4; pkts[3] = 1;
    drive_src();
    #1;
    tick(); expm("D1", 1'b0, 64'h0, 1'b0, 0);
    tick(); expm("D2", 1'b1, bd(3, 1, 0), 1'b0, 3);
    tick(); expm("D3", 1'b1, bd(3, 1, 1), 1'b0, 3);
    tick(); expm("D4", 1'b1, bd(3, 1, 2), 1'b0, 3);
    rst = 1'b1;
    #1;
    chk("D_rst_vld",  64'(bus.m_tvalid), 64'h0);
    chk("D_rst_data", bus.m_tdata,       64'h0);
    chk("D_rst_rdy",  64'(bus.s_tready), 64'h0);
    beat[3] = 0; pid[3] = 2; pkts[3] = 1;
    drive_src();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tick(); expm("D5", 1'b0, 64'h0, 1'b0, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      expm($sformatf("D_new%0d", b), 1'b1, bd(3, 2, b), (b == 3), 3);
    end
    tick(); expm("D6", 1'b0, 64'h0, 1'b0, 0);

    // ---- F: ch2 10-beat packet at full rate
    len[2] = 10; pkts[2] = 1;
    drive_src();
    #1;
    tick(); expm("F0", 1'b0, 64'h0, 1'b0, 0);
    for (int b = 0; b < 10; b++) begin
      tick();
      expm($sformatf("F_b%0d", b), 1'b1, bd(2, 2, b), (b == 9), 2);
    end
    tick(); expm("F11", 1'b0, 64'h0, 1'b0, 0);

`ifdef OFS_FIM_ETH_ARB_PKT_CNT_EN
    // since the last reset: one ch3 packet and one ch2 packet
    chk("cnt_ch0", 64'(pkt_cnt[0*32 +: 32]), 64'h0);
    chk("cnt_ch2", 64'(pkt_cnt[2*32 +: 32]), 64'h1);
    chk("cnt_ch3", 64'(pkt_cnt[3*32 +: 32]), 64'h1);
    dut.g_cnt[1].cnt = 32'hFFFF_FFFE;
    len[1] = 1; pkts[1] = 2;
    drive_src();
    #1;
    tick(); tick(); tick();
    chk("cnt_ch1_max", 64'(pkt_cnt[1*32 +: 32]), 64'hFFFF_FFFF);
    tick(); tick();
    chk("cnt_ch1_wrap", 64'(pkt_cnt[1*32 +: 32]), 64'h0);
`else
    chk("cnt_tied0", 64'(pkt_cnt[63:0] | pkt_cnt[127:64]), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
